game_ctrl: RTL and testbench

Frame-rate game sequencer for Breakout. Sequences the ball datapath through attract, serve, play, miss and end-of-game phases. Holds the ball at its serve position or releases it; tracks lives and a 4-digit BCD score. Runs on the same frame clock as the ball and paddle blocks, and its outputs drive the ball's hold/reset and motion-enable inputs.

---
 rtl/breakout_pkg.sv | 17 +
 rtl/game_ctrl_if.sv | 25 ++
 rtl/bcd_score_counter.sv | 47 ++++
 rtl/game_ctrl.sv | 136 +++++++++++++
 tb/tb_game_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout frame-rate game sequencer.
package breakout_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StPlay     = 3'd2,
        StMiss     = 3'd3,
        StGameOver = 3'd4,
        StWin      = 3'd5
    } game_state_e;

    localparam logic [7:0]  KEY_SPACE = 8'h2C;
    localparam logic [7:0]  KEY_P     = 8'h13;
    localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/game_ctrl_if.sv
// Key/event inputs and ball-control/status outputs of the game sequencer.
// master: the sequencer side; slave: the ball datapath / display side.
interface game_ctrl_if;
    logic [7:0]  keycode;
    logic        ball_miss;
    logic        brick_hit;
    logic [6:0]  bricks_left;
    logic        ball_hold;
    logic        ball_run;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [2:0]  game_state;
    logic        game_over;
    logic        win;

    modport master (
        input  keycode, ball_miss, brick_hit, bricks_left,
        output ball_hold, ball_run, lives, score_bcd, game_state, game_over, win
    );

    modport slave (
        output keycode, ball_miss, brick_hit, bricks_left,
        input  ball_hold, ball_run, lives, score_bcd, game_state, game_over, win
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Four-digit BCD accumulator with synchronous clear; saturates at 9999 instead of wrapping.
module bcd_score_counter
    import breakout_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        add_en,
    input  logic [3:0]  addend,
    output logic [15:0] score
);

    logic [15:0] score_q;
    logic [15:0] sum;
    logic [4:0]  dig;
    logic        carry;

    // Ripple the addend through the digits; a carry out of the thousands means overflow.
    always_comb begin
        sum   = '0;
        dig   = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dig = {1'b0, score_q[4*i +: 4]} + {4'b0, carry} + ((i == 0) ? {1'b0, addend} : 5'd0);
            if (dig > 5'd9) begin
                sum[4*i +: 4] = 4'(dig - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = dig[3:0];
                carry         = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
        end else if (clear) begin
            score_q <= '0;
        end else if (add_en) begin
            score_q <= carry ? SCORE_MAX : sum;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer: attract, serve, play, miss and end-of-game phases.
// Optional BREAKOUT_PAUSE_EN adds a P-key pause toggle while in play.
module game_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned MISS_FRAMES  = 60,
    parameter int unsigned BRICK_POINTS = 1
) (
    input  logic frame_clk,
    input  logic Reset,
    game_ctrl_if.master bus
);

    game_state_e state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  key_prev_q;
    logic [1:0]  lives_q, lives_d;
    logic        space_edge;
    logic        score_clear;
    logic        score_add;
    logic        paused;

    assign space_edge = (bus.keycode == KEY_SPACE) && (key_prev_q != KEY_SPACE);

`ifdef BREAKOUT_PAUSE_EN
    logic paused_q, paused_d;
    logic p_edge;

    assign p_edge = (bus.keycode == KEY_P) && (key_prev_q != KEY_P);
    assign paused = paused_q;

    always_comb begin
        paused_d = paused_q;
        if (state_q == StPlay && p_edge) begin
            paused_d = !paused_q;
        end
        if (state_d != StPlay) begin
            paused_d = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_d;
        end
    end
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lives_d     = lives_q;
        score_clear = 1'b0;
        score_add   = 1'b0;
        case (state_q)
            StIdle: begin
                if (space_edge) begin
                    state_d     = StServe;
                    lives_d     = 2'(LIVES_INIT);
                    score_clear = 1'b1;
                    timer_d     = 8'(SERVE_FRAMES);
                end
            end
            StServe: begin
                if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
                if (space_edge || timer_q == 8'd1) state_d = StPlay;
            end
            StPlay: begin
                // Clearing the field wins even if the last ball is lost in the same frame.
                if (!paused) begin
                    score_add = bus.brick_hit;
                    if (bus.bricks_left == 7'd0) begin
                        state_d = StWin;
                    end else if (bus.ball_miss) begin
                        state_d = StMiss;
                        lives_d = lives_q - 2'd1;
                        timer_d = 8'(MISS_FRAMES);
                    end
                end
            end
            StMiss: begin
                if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
                if (timer_q == 8'd1) begin
                    if (lives_q == 2'd0) begin
                        state_d = StGameOver;
                    end else begin
                        state_d = StServe;
                        timer_d = 8'(SERVE_FRAMES);
                    end
                end
            end
            StGameOver, StWin: begin
                if (space_edge) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            lives_q    <= '0;
            key_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lives_q    <= lives_d;
            key_prev_q <= bus.keycode;
        end
    end

    bcd_score_counter u_score (
        .clk    (frame_clk),
        .rst    (Reset),
        .clear  (score_clear),
        .add_en (score_add),
        .addend (4'(BRICK_POINTS)),
        .score  (bus.score_bcd)
    );

    // MISS freezes the ball where it is; every other non-play state parks it at serve.
    assign bus.ball_hold  = (state_q != StPlay) && (state_q != StMiss);
    assign bus.ball_run   = (state_q == StPlay) && !paused;
    assign bus.lives      = lives_q;
    assign bus.game_state = state_q;
    assign bus.game_over  = (state_q == StGameOver);
    assign bus.win        = (state_q == StWin);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected outputs, a monitor compares them.
module tb_game_ctrl;
    import breakout_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        hold;
        logic        run;
        logic [1:0]  lives;
        logic [15:0] score;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    event  probe_ev;

    game_ctrl_if bus ();

    game_ctrl #(
        .LIVES_INIT   (3),
        .SERVE_FRAMES (120),
        .MISS_FRAMES  (60),
        .BRICK_POINTS (1)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial forever #5 frame_clk = ~frame_clk;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: drains every expectation queued before the probe fired.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(probe_ev);
            while (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "state",     int'(bus.game_state), int'(e.st));
                cmp(nm, "ball_hold", int'(bus.ball_hold),  int'(e.hold));
                cmp(nm, "ball_run",  int'(bus.ball_run),   int'(e.run));
                cmp(nm, "lives",     int'(bus.lives),      int'(e.lives));
                cmp(nm, "score",     int'(bus.score_bcd),  int'(e.score));
                cmp(nm, "game_over", int'(bus.game_over),  int'(e.st == 3'd4));
                cmp(nm, "win",       int'(bus.win),        int'(e.st == 3'd5));
            end
        end
    end

    task automatic push_exp(input string nm, input int st, input int hold, input int run,
                            input int lives, input logic [15:0] score);
        exp_t e;
        e.st    = 3'(st);
        e.hold  = 1'(hold);
        e.run   = 1'(run);
        e.lives = 2'(lives);
        e.score = score;
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->probe_ev;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    // Press for one frame, then release for one frame so the next press is a fresh edge.
    task automatic tap(input logic [7:0] k);
        bus.keycode = k;
        cyc(1);
        bus.keycode = 8'h00;
        cyc(1);
    endtask

    initial begin
        bus.keycode     = 8'h00;
        bus.ball_miss   = 1'b0;
        bus.brick_hit   = 1'b0;
        bus.bricks_left = 7'd50;

        cyc(1);
        push_exp("reset", 0, 1, 0, 0, 16'h0000);
        Reset = 1'b0;

        // Space held three frames: one edge only, then auto-launch 120 frames after entry.
        bus.keycode = KEY_SPACE;
        cyc(1);
        push_exp("serve_entry", 1, 1, 0, 3, 16'h0000);
        cyc(2);
        push_exp("serve_held", 1, 1, 0, 3, 16'h0000);
        bus.keycode = 8'h00;
        cyc(117);
        push_exp("serve_last", 1, 1, 0, 3, 16'h0000);
        cyc(1);
        push_exp("play_auto", 2, 0, 1, 3, 16'h0000);

        for (int i = 1; i <= 12; i++) begin
            bus.brick_hit = 1'b1;
            cyc(1);
            bus.brick_hit = 1'b0;
            if (i == 1)  push_exp("score_1", 2, 0, 1, 3, 16'h0001);
            if (i == 10) push_exp("score_10", 2, 0, 1, 3, 16'h0010);
            if (i == 12) push_exp("score_12", 2, 0, 1, 3, 16'h0012);
            cyc(1);
        end

        // Hit and miss together: point scored and miss taken.
        bus.ball_miss = 1'b1;
        bus.brick_hit = 1'b1;
        cyc(1);
        bus.ball_miss = 1'b0;
        bus.brick_hit = 1'b0;
        push_exp("miss_hit", 3, 0, 0, 2, 16'h0013);
        bus.brick_hit = 1'b1;
        cyc(1);
        bus.brick_hit = 1'b0;
        push_exp("hit_in_miss", 3, 0, 0, 2, 16'h0013);
        cyc(58);
        push_exp("miss_last", 3, 0, 0, 2, 16'h0013);
        cyc(1);
        push_exp("serve_after_miss", 1, 1, 0, 2, 16'h0013);
        cyc(120);
        push_exp("play_2", 2, 0, 1, 2, 16'h0013);

        bus.brick_hit = 1'b1;
        cyc(9985);
        push_exp("score_9998", 2, 0, 1, 2, 16'h9998);
        cyc(1);
        push_exp("score_9999", 2, 0, 1, 2, 16'h9999);
        cyc(1);
        push_exp("score_sat", 2, 0, 1, 2, 16'h9999);
        bus.brick_hit = 1'b0;

        bus.ball_miss = 1'b1;
        cyc(1);
        bus.ball_miss = 1'b0;
        push_exp("miss_2", 3, 0, 0, 1, 16'h9999);
        cyc(60);
        push_exp("serve_3", 1, 1, 0, 1, 16'h9999);
        cyc(5);
        tap(KEY_SPACE);
        push_exp("serve_space", 2, 0, 1, 1, 16'h9999);

        bus.ball_miss = 1'b1;
        cyc(1);
        bus.ball_miss = 1'b0;
        push_exp("miss_3", 3, 0, 0, 0, 16'h9999);
        cyc(59);
        push_exp("miss_before_go", 3, 0, 0, 0, 16'h9999);
        cyc(1);
        push_exp("game_over", 4, 1, 0, 0, 16'h9999);

        tap(KEY_SPACE);
        push_exp("go_to_idle", 0, 1, 0, 0, 16'h9999);
        tap(KEY_SPACE);
        push_exp("restart", 1, 1, 0, 3, 16'h0000);
        tap(KEY_SPACE);
        push_exp("play_3", 2, 0, 1, 3, 16'h0000);

        // Field cleared in the same frame as a miss: WIN, no life lost.
        bus.bricks_left = 7'd0;
        bus.ball_miss   = 1'b1;
        cyc(1);
        bus.bricks_left = 7'd50;
        bus.ball_miss   = 1'b0;
        push_exp("win", 5, 1, 0, 3, 16'h0000);
        tap(KEY_SPACE);
        push_exp("win_to_idle", 0, 1, 0, 3, 16'h0000);
        tap(KEY_SPACE);
        tap(KEY_SPACE);
        bus.ball_miss = 1'b1;
        cyc(1);
        bus.ball_miss = 1'b0;
        push_exp("miss_4", 3, 0, 0, 2, 16'h0000);
        cyc(10);

        // Asynchronous reset between clock edges.
        @(posedge frame_clk);
        #2;
        Reset = 1'b1;
        #1;
        push_exp("async_reset", 0, 1, 0, 0, 16'h0000);
        cyc(1);
        Reset = 1'b0;

        tap(KEY_SPACE);
        tap(KEY_SPACE);
        push_exp("play_4", 2, 0, 1, 3, 16'h0000);
        tap(KEY_P);
`ifdef BREAKOUT_PAUSE_EN
        push_exp("paused", 2, 0, 0, 3, 16'h0000);
        bus.ball_miss   = 1'b1;
        bus.brick_hit   = 1'b1;
        bus.bricks_left = 7'd0;
        cyc(1);
        bus.ball_miss   = 1'b0;
        bus.brick_hit   = 1'b0;
        bus.bricks_left = 7'd50;
        push_exp("paused_events", 2, 0, 0, 3, 16'h0000);
        tap(KEY_P);
        push_exp("unpaused", 2, 0, 1, 3, 16'h0000);
`else
        push_exp("p_no_effect", 2, 0, 1, 3, 16'h0000);
        bus.ball_miss = 1'b1;
        cyc(1);
        bus.ball_miss = 1'b0;
        push_exp("p_then_miss", 3, 0, 0, 2, 16'h0000);
`endif

        cyc(1);
        ->probe_ev;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
